// File: rtl/mrv2_sys_fu.sv
// System functional unit: per-thread CSRs with single-cycle access and a thread spawn/exit handshake.
// Optional free-running cycle CSR compiled in with MRV_SYS_FU_CYCLE_CSR_EN.
package mrv2_sys_fu_pkg;
    typedef enum logic [2:0] {
        CSR_READ  = 3'd0,
        CSR_WRITE = 3'd1,
        CSR_SET   = 3'd2,
        CSR_CLR   = 3'd3,
        TSPAWN    = 3'd4,
        TEXIT     = 3'd5
    } mrv_sys_fu_op_e;
endpackage

module mrv2_sys_fu
    import mrv2_sys_fu_pkg::*;
#(
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_THREADS_P = 4,
    parameter int PC_WIDTH_P    = 32,
    parameter int NUM_SCRATCH_P = 2,
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH_P-1:0] exec_src0_data_i,
    input  logic [DATA_WIDTH_P-1:0] exec_src1_data_i,
    input  logic [ITAG_WIDTH_P-1:0] exec_itag_i,
    input  logic [TID_WIDTH_LP-1:0] exec_tid_i,
    input  mrv_sys_fu_op_e          sys_fu_opc_i,
    input  logic                    sys_fu_req_i,
    output logic                    sys_fu_rdy_o,
    output logic                    sys_fu_done_o,
    output logic [DATA_WIDTH_P-1:0] sys_fu_res_o,
    output logic [ITAG_WIDTH_P-1:0] sys_fu_itag_o,
    output logic [TID_WIDTH_LP-1:0] sys_fu_tid_o,
    output logic                    th_ctl_vld_o,
    input  logic                    th_ctl_rdy_i,
    output logic [TID_WIDTH_LP-1:0] th_ctl_tid_o,
    output logic                    th_ctl_tspawn_vld_o,
    output logic [PC_WIDTH_P-1:0]   th_ctl_tspawn_pc_o
);
    localparam int THR_DEPTH_LP = 1 << TID_WIDTH_LP;
    localparam int SCR_DEPTH_LP = 8;

    typedef enum logic [1:0] {IDLE, TCTL, DONE} state_e;

    state_e                  state_q;
    logic                    accept;
    logic                    is_tctl;
    logic                    is_wr;
    logic                    scr_hit;
    logic                    tid_ok;
    logic                    spawn_bad;
    logic [11:0]             csr_addr;
    logic [2:0]              scr_sel;
    logic [DATA_WIDTH_P-1:0] csr_old;
    logic [DATA_WIDTH_P-1:0] csr_new;
    logic [DATA_WIDTH_P-1:0] tctl_res_q;
    logic [ITAG_WIDTH_P-1:0] tctl_itag_q;
    logic [TID_WIDTH_LP-1:0] tctl_tid_q;
    // Storage is padded to power-of-two depths; only legal entries are ever written.
    logic [DATA_WIDTH_P-1:0] scratch_q [THR_DEPTH_LP][SCR_DEPTH_LP];

    assign sys_fu_rdy_o = (state_q == IDLE);
    assign accept       = sys_fu_req_i && sys_fu_rdy_o;
    assign is_tctl      = (sys_fu_opc_i == TSPAWN) || (sys_fu_opc_i == TEXIT);
    assign csr_addr     = exec_src1_data_i[11:0];
    assign scr_sel      = csr_addr[2:0];
    assign scr_hit      = (csr_addr[11:3] == 9'h100) && (int'(scr_sel) < NUM_SCRATCH_P);
    assign tid_ok       = int'(exec_tid_i) < NUM_THREADS_P;
    assign spawn_bad    = (exec_src1_data_i >= DATA_WIDTH_P'(NUM_THREADS_P)) ||
                          (exec_src1_data_i[TID_WIDTH_LP-1:0] == exec_tid_i);
    assign is_wr        = accept && scr_hit && tid_ok &&
                          ((sys_fu_opc_i == CSR_WRITE) || (sys_fu_opc_i == CSR_SET) ||
                           (sys_fu_opc_i == CSR_CLR));

`ifdef MRV_SYS_FU_CYCLE_CSR_EN
    logic [63:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cycle_q <= '0;
        else       cycle_q <= cycle_q + 64'd1;
    end
`endif

    always_comb begin
        csr_old = '0;
        if (scr_hit && tid_ok)
            csr_old = scratch_q[exec_tid_i][scr_sel];
        else if (csr_addr == 12'hF14)
            csr_old = DATA_WIDTH_P'(exec_tid_i);
`ifdef MRV_SYS_FU_CYCLE_CSR_EN
        else if (csr_addr == 12'hC00)
            csr_old = DATA_WIDTH_P'(cycle_q);
        else if ((csr_addr == 12'hC80) && (DATA_WIDTH_P == 32))
            csr_old = DATA_WIDTH_P'(cycle_q >> 32);
`endif
    end

    always_comb begin
        case (sys_fu_opc_i)
            CSR_WRITE: csr_new = exec_src0_data_i;
            CSR_SET:   csr_new = csr_old | exec_src0_data_i;
            CSR_CLR:   csr_new = csr_old & ~exec_src0_data_i;
            default:   csr_new = csr_old;
        endcase
    end

    // Write lands on the accept edge so a following read already sees it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < THR_DEPTH_LP; t++)
                for (int s = 0; s < SCR_DEPTH_LP; s++)
                    scratch_q[t][s] <= '0;
        end else if (is_wr) begin
            scratch_q[exec_tid_i][scr_sel] <= csr_new;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            sys_fu_done_o       <= 1'b0;
            sys_fu_res_o        <= '0;
            sys_fu_itag_o       <= '0;
            sys_fu_tid_o        <= '0;
            th_ctl_vld_o        <= 1'b0;
            th_ctl_tid_o        <= '0;
            th_ctl_tspawn_vld_o <= 1'b0;
            th_ctl_tspawn_pc_o  <= '0;
            tctl_res_q          <= '0;
            tctl_itag_q         <= '0;
            tctl_tid_q          <= '0;
        end else begin
            sys_fu_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && !is_tctl) begin
                        sys_fu_done_o <= 1'b1;
                        sys_fu_res_o  <= csr_old;
                        sys_fu_itag_o <= exec_itag_i;
                        sys_fu_tid_o  <= exec_tid_i;
                    end else if (accept && (sys_fu_opc_i == TSPAWN) && spawn_bad) begin
                        sys_fu_done_o <= 1'b1;
                        sys_fu_res_o  <= '1;
                        sys_fu_itag_o <= exec_itag_i;
                        sys_fu_tid_o  <= exec_tid_i;
                        state_q       <= DONE;
                    end else if (accept) begin
                        tctl_itag_q         <= exec_itag_i;
                        tctl_tid_q          <= exec_tid_i;
                        th_ctl_vld_o        <= 1'b1;
                        if (sys_fu_opc_i == TSPAWN) begin
                            th_ctl_tspawn_vld_o <= 1'b1;
                            th_ctl_tid_o        <= exec_src1_data_i[TID_WIDTH_LP-1:0];
                            th_ctl_tspawn_pc_o  <= PC_WIDTH_P'(exec_src0_data_i);
                            tctl_res_q          <= DATA_WIDTH_P'(exec_src1_data_i[TID_WIDTH_LP-1:0]);
                        end else begin
                            th_ctl_tspawn_vld_o <= 1'b0;
                            th_ctl_tid_o        <= exec_tid_i;
                            tctl_res_q          <= '0;
                        end
                        state_q <= TCTL;
                    end
                end
                TCTL: begin
                    if (th_ctl_rdy_i) begin
                        th_ctl_vld_o        <= 1'b0;
                        th_ctl_tspawn_vld_o <= 1'b0;
                        sys_fu_done_o       <= 1'b1;
                        sys_fu_res_o        <= tctl_res_q;
                        sys_fu_itag_o       <= tctl_itag_q;
                        sys_fu_tid_o        <= tctl_tid_q;
                        state_q             <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mrv2_sys_fu.sv
// Bench for mrv2_sys_fu: CSR vector table, randomized CSR traffic against a model, thread-control sequences.
module tb_mrv2_sys_fu;
    import mrv2_sys_fu_pkg::*;

    localparam int NT = 4;
    localparam int NS = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    src0, src1;
    logic [2:0]     itag;
    logic [1:0]     tid;
    mrv_sys_fu_op_e opc;
    logic           req;
    logic           rdy, done;
    logic [31:0]    res;
    logic [2:0]     itag_o;
    logic [1:0]     tid_o;
    logic           th_vld, th_rdy, th_spawn;
    logic [1:0]     th_tid;
    logic [31:0]    th_pc;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] mscr [NT][NS];

    always #5 clk = ~clk;

    mrv2_sys_fu dut (
        .clk_i(clk), .rst_i(rst),
        .exec_src0_data_i(src0), .exec_src1_data_i(src1),
        .exec_itag_i(itag), .exec_tid_i(tid),
        .sys_fu_opc_i(opc), .sys_fu_req_i(req), .sys_fu_rdy_o(rdy),
        .sys_fu_done_o(done), .sys_fu_res_o(res), .sys_fu_itag_o(itag_o), .sys_fu_tid_o(tid_o),
        .th_ctl_vld_o(th_vld), .th_ctl_rdy_i(th_rdy), .th_ctl_tid_o(th_tid),
        .th_ctl_tspawn_vld_o(th_spawn), .th_ctl_tspawn_pc_o(th_pc)
    );

    typedef struct {
        mrv_sys_fu_op_e op;
        logic [1:0]     t;
        logic [11:0]    a;
        logic [31:0]    s;
        logic [31:0]    exp;
    } vec_t;
    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input int t, input logic [11:0] a);
        if (int'(a) >= 'h800 && int'(a) < 'h800 + NS) return mscr[t][int'(a) - 'h800];
        if (a == 12'hF14) return 32'(t);
        return 32'h0;
    endfunction

    function automatic void model_exec(input mrv_sys_fu_op_e op, input int t,
                                       input logic [11:0] a, input logic [31:0] s);
        logic [31:0] old;
        old = ref_read(t, a);
        if (int'(a) >= 'h800 && int'(a) < 'h800 + NS) begin
            case (op)
                CSR_WRITE: mscr[t][int'(a) - 'h800] = s;
                CSR_SET:   mscr[t][int'(a) - 'h800] = old | s;
                CSR_CLR:   mscr[t][int'(a) - 'h800] = old & ~s;
                default:   ;
            endcase
        end
    endfunction

    task automatic csr_op(input mrv_sys_fu_op_e op, input logic [1:0] t, input logic [11:0] a,
                          input logic [31:0] s, input logic [2:0] it, input logic [31:0] exp,
                          input string nm);
        opc = op; tid = t; src1 = {20'h0, a}; src0 = s; itag = it; req = 1'b1;
        check({nm, " rdy"}, rdy, 1);
        tick();
        check({nm, " done"}, done, 1);
        check({nm, " res"}, res, exp);
        check({nm, " itag"}, itag_o, it);
        check({nm, " tid"}, tid_o, t);
        model_exec(op, t, a, s);
    endtask

    task automatic issue(input mrv_sys_fu_op_e op, input logic [1:0] t, input logic [31:0] s0,
                         input logic [31:0] s1, input logic [2:0] it);
        opc = op; tid = t; src0 = s0; src1 = s1; itag = it; req = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c1, c2;
        rst = 1'b1; req = 1'b0; opc = CSR_READ; src0 = '0; src1 = '0; itag = '0; tid = '0; th_rdy = 1'b0;
        for (int t = 0; t < NT; t++) for (int s = 0; s < NS; s++) mscr[t][s] = '0;
        tick(); tick();
        check("rst done", done, 0);
        check("rst th_vld", th_vld, 0);
        check("rst th_spawn", th_spawn, 0);
        check("rst res", res, 0);
        check("rst pc", th_pc, 0);
        rst = 1'b0;
        check("rst release rdy", rdy, 1);

        vecs[0]  = '{CSR_WRITE, 2'd1, 12'h800, 32'hA5, 32'h0};
        vecs[1]  = '{CSR_READ,  2'd1, 12'h800, 32'h0,  32'hA5};
        vecs[2]  = '{CSR_READ,  2'd0, 12'h800, 32'h0,  32'h0};
        vecs[3]  = '{CSR_SET,   2'd2, 12'h801, 32'h0F, 32'h0};
        vecs[4]  = '{CSR_CLR,   2'd2, 12'h801, 32'h03, 32'h0F};
        vecs[5]  = '{CSR_READ,  2'd2, 12'h801, 32'h0,  32'h0C};
        vecs[6]  = '{CSR_READ,  2'd3, 12'hF14, 32'h0,  32'h3};
        vecs[7]  = '{CSR_WRITE, 2'd3, 12'hF14, 32'hFF, 32'h3};
        vecs[8]  = '{CSR_READ,  2'd3, 12'hF14, 32'h0,  32'h3};
        vecs[9]  = '{CSR_WRITE, 2'd0, 12'h802, 32'h55, 32'h0};
        vecs[10] = '{CSR_READ,  2'd0, 12'h802, 32'h0,  32'h0};
        vecs[11] = '{CSR_SET,   2'd1, 12'h800, 32'h0,  32'hA5};
        vecs[12] = '{CSR_CLR,   2'd1, 12'h800, 32'h0,  32'hA5};
        vecs[13] = '{CSR_READ,  2'd1, 12'h800, 32'h0,  32'hA5};
        for (int i = 0; i < 14; i++)
            csr_op(vecs[i].op, vecs[i].t, vecs[i].a, vecs[i].s, 3'(i), vecs[i].exp, $sformatf("vec%0d", i));
        req = 1'b0;
        tick();
        check("idle done", done, 0);

        for (int i = 0; i < 150; i++) begin
            logic [11:0] alist [6];
            mrv_sys_fu_op_e rop;
            logic [1:0] rt;
            logic [11:0] ra;
            logic [31:0] rs;
            alist = '{12'h800, 12'h801, 12'h802, 12'hF14, 12'h7FF, 12'hABC};
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b0;
                tick();
                check("rand gap done", done, 0);
            end
            rop = mrv_sys_fu_op_e'(3'($urandom_range(0, 3)));
            rt  = 2'($urandom_range(0, NT - 1));
            ra  = alist[$urandom_range(0, 5)];
            rs  = $urandom;
            csr_op(rop, rt, ra, rs, 3'($urandom_range(0, 7)), ref_read(int'(rt), ra), $sformatf("rand%0d", i));
        end
        req = 1'b0;
        tick();

        // Spawn with a stalled handshake; requests during the stall must be ignored.
        issue(TSPAWN, 2'd0, 32'h1000, 32'd2, 3'd5);
        th_rdy = 1'b0;
        tick();
        issue(CSR_WRITE, 2'd0, 32'h99, 32'h801, 3'd1);
        for (int i = 0; i < 3; i++) begin
            check("spawn wait vld", th_vld, 1);
            check("spawn wait kind", th_spawn, 1);
            check("spawn wait pc", th_pc, 32'h1000);
            check("spawn wait tid", th_tid, 2);
            check("spawn wait rdy", rdy, 0);
            check("spawn wait done", done, 0);
            tick();
        end
        req = 1'b0;
        th_rdy = 1'b1;
        tick();
        th_rdy = 1'b0;
        check("spawn done", done, 1);
        check("spawn res", res, 2);
        check("spawn itag", itag_o, 5);
        check("spawn tid", tid_o, 0);
        check("spawn vld drop", th_vld, 0);
        tick();
        check("spawn done once", done, 0);
        check("spawn back idle", rdy, 1);
        csr_op(CSR_READ, 2'd0, 12'h801, 32'h0, 3'd2, ref_read(0, 12'h801), "stalled req ignored");
        req = 1'b0;
        tick();

        issue(TSPAWN, 2'd1, 32'h2000, 32'd1, 3'd3);
        tick();
        req = 1'b0;
        check("self spawn done", done, 1);
        check("self spawn res", res, 32'hFFFFFFFF);
        check("self spawn vld", th_vld, 0);
        check("self spawn itag", itag_o, 3);
        tick();
        check("self spawn once", done, 0);
        check("self spawn vld2", th_vld, 0);
        check("self spawn rdy", rdy, 1);

        issue(TSPAWN, 2'd0, 32'h2000, 32'd5, 3'd4);
        tick();
        req = 1'b0;
        check("oor spawn res", res, 32'hFFFFFFFF);
        check("oor spawn vld", th_vld, 0);
        tick();

        issue(TEXIT, 2'd3, 32'h0, 32'h0, 3'd2);
        th_rdy = 1'b1;
        tick();
        req = 1'b0;
        check("exit vld", th_vld, 1);
        check("exit kind", th_spawn, 0);
        check("exit tid", th_tid, 3);
        check("exit early done", done, 0);
        tick();
        th_rdy = 1'b0;
        check("exit done", done, 1);
        check("exit res", res, 0);
        check("exit itag", itag_o, 2);
        check("exit tid_o", tid_o, 3);
        tick();
        check("exit once", done, 0);

        // Reset while a handshake is outstanding.
        csr_op(CSR_WRITE, 2'd1, 12'h800, 32'h77, 3'd6, ref_read(1, 12'h800), "pre-rst write");
        req = 1'b0;
        tick();
        issue(TEXIT, 2'd1, 32'h0, 32'h0, 3'd7);
        tick();
        req = 1'b0;
        check("rst mid vld", th_vld, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid done", done, 0);
        check("rst mid vld0", th_vld, 0);
        check("rst mid res", res, 0);
        check("rst mid itag", itag_o, 0);
        check("rst mid rdy", rdy, 1);
        tick();
        check("rst mid no done", done, 0);
        for (int t = 0; t < NT; t++) for (int s = 0; s < NS; s++) mscr[t][s] = '0;
        csr_op(CSR_READ, 2'd1, 12'h800, 32'h0, 3'd1, ref_read(1, 12'h800), "post-rst scratch");
        req = 1'b0;
        tick();

        issue(CSR_READ, 2'd0, 32'h0, 32'hC00, 3'd0);
        tick();
        c1 = res;
        req = 1'b0;
        repeat (6) tick();
        req = 1'b1;
        tick();
        c2 = res;
        req = 1'b0;
`ifdef MRV_SYS_FU_CYCLE_CSR_EN
        check("cycle delta", c2 - c1, 7);
`else
        check("cycle off first", c1, 0);
        check("cycle off second", c2, 0);
        csr_op(CSR_READ, 2'd0, 12'hC80, 32'h0, 3'd0, 32'h0, "cycle hi off");
        req = 1'b0;
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
